// File: rtl/vec4_denormalizer.sv
// vec4_denormalizer: rebuilds four components as round(Q_i * mag / 2^FRAC_BITS) with one shared multiplier
module vec4_denormalizer #(
  parameter int DATAWIDTH = 8,
  parameter int FRAC_BITS = 8,
  parameter int QWIDTH    = 2*DATAWIDTH+2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [QWIDTH-1:0]    Q_A,
  input  logic [QWIDTH-1:0]    Q_B,
  input  logic [QWIDTH-1:0]    Q_C,
  input  logic [QWIDTH-1:0]    Q_D,
  input  logic [QWIDTH-1:0]    mag,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [DATAWIDTH-1:0] out_A,
  output logic [DATAWIDTH-1:0] out_B,
  output logic [DATAWIDTH-1:0] out_C,
  output logic [DATAWIDTH-1:0] out_D,
  output logic [3:0]           o_sat,
  output logic                 o_zero_mag
);
  localparam int PW = 2*QWIDTH;
  localparam logic [PW-1:0] HALF = {{(PW-1){1'b0}}, 1'b1} << (FRAC_BITS-1);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t                state_q;
  logic [1:0]            idx_q;
  logic [QWIDTH-1:0]     q_q [4];
  logic [QWIDTH-1:0]     mag_q;
  logic [DATAWIDTH-1:0]  out_q [4];
  logic [PW-1:0]         prod_d, rnd_d;
  logic [DATAWIDTH-1:0]  res_d;
  logic                  sat_d;
  // full-width product; the rounding add cannot carry out of PW bits
  always_comb begin
    prod_d = {{QWIDTH{1'b0}}, q_q[idx_q]} * {{QWIDTH{1'b0}}, mag_q};
    rnd_d  = (prod_d + HALF) >> FRAC_BITS;
    sat_d  = |rnd_d[PW-1:DATAWIDTH];
    res_d  = sat_d ? '1 : rnd_d[DATAWIDTH-1:0];
  end
  assign i_ready = state_q == IDLE;
  assign out_A   = out_q[0];
  assign out_B   = out_q[1];
  assign out_C   = out_q[2];
  assign out_D   = out_q[3];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      q_q        <= '{default: '0};
      mag_q      <= '0;
      out_q      <= '{default: '0};
      o_sat      <= '0;
      o_zero_mag <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          q_q        <= '{Q_A, Q_B, Q_C, Q_D};
          mag_q      <= mag;
          idx_q      <= '0;
          o_sat      <= '0;
          o_zero_mag <= mag == '0;
          state_q    <= MUL;
        end
        MUL: begin
          out_q[idx_q] <= res_d;
          o_sat[idx_q] <= sat_d;
          idx_q        <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= DONE;
        end
        // o_valid rises one cycle after the last lane is written
        DONE: if (!o_valid) o_valid <= 1'b1;
          else if (o_ready) begin
            o_valid <= 1'b0;
            state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec4_denormalizer.sv
// tb_vec4_denormalizer: random and directed vectors against an arithmetic reference, scoreboard-checked
module tb_vec4_denormalizer;
  localparam int DW = 8, FB = 8, QW = 2*DW+2;
  logic clk = 1'b0, rst = 1'b0, i_valid = 1'b0, i_ready, o_valid;
  logic o_ready = 1'b1;
  logic [QW-1:0] qa = '0, qb = '0, qc = '0, qd = '0, mg = '0;
  logic [DW-1:0] oa, ob, oc, od;
  logic [3:0] osat;
  logic ozm;
  typedef struct packed {logic [31:0] outs; logic [3:0] sat; logic zm; logic [31:0] acc;} exp_t;
  exp_t sb[$];
  int cyc = 0, napplied = 0, nerr = 0, ncmp = 0;
  int last_acc = 0;
  bit rnd_bp = 0, ready_force = 1, pv = 0;

  vec4_denormalizer #(.DATAWIDTH(DW), .FRAC_BITS(FB), .QWIDTH(QW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .Q_A(qa), .Q_B(qb), .Q_C(qc), .Q_D(qd), .mag(mg),
    .o_valid(o_valid), .o_ready(o_ready),
    .out_A(oa), .out_B(ob), .out_C(oc), .out_D(od),
    .o_sat(osat), .o_zero_mag(ozm));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #2;
    o_ready = rnd_bp ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // reference: exact integer rounding of Q*mag/2^FB, clamped to DW bits
  function automatic exp_t model(input logic [QW-1:0] a, b, c, d, m, input int acc);
    longint unsigned q, r;
    exp_t e;
    e.outs = '0;
    e.sat  = '0;
    e.zm   = (m == 0);
    e.acc  = acc;
    for (int i = 0; i < 4; i++) begin
      q = (i == 0) ? longint'(a) : (i == 1) ? longint'(b) : (i == 2) ? longint'(c) : longint'(d);
      r = (q * longint'(m) + (64'd1 << (FB-1))) / (64'd1 << FB);
      if (r > 64'd255) begin
        e.sat[i] = 1'b1;
        e.outs[8*i +: 8] = 8'hFF;
      end else e.outs[8*i +: 8] = r[7:0];
    end
    return e;
  endfunction

  // called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [QW-1:0] a, b, c, d, m);
    int w = 0;
    qa = a; qb = b; qc = c; qd = d; mg = m;
    i_valid = 1'b1;
    while (!i_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!i_ready) begin
      ncmp++; nerr++;
      $display("FAIL accept_timeout: i_ready stayed 0 for %0d cycles", w);
      i_valid = 1'b0;
      return;
    end
    napplied++;
    last_acc = cyc + 1;
    sb.push_back(model(a, b, c, d, m, cyc + 1));
    @(posedge clk); #1;
    i_valid = 1'b0;
    qa = QW'($urandom); qb = QW'($urandom); qc = QW'($urandom); qd = QW'($urandom); mg = QW'($urandom);
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((sb.size() != 0 || !i_ready) && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() != 0 || !i_ready) begin
      ncmp++; nerr++;
      $display("FAIL drain_timeout: %0d vectors still pending", sb.size());
    end
  endtask

  function automatic logic [QW-1:0] rq();
    return ($urandom_range(0, 1) != 0) ? QW'($urandom_range(0, 300)) : QW'($urandom_range(0, (1 << QW) - 1));
  endfunction

  function automatic logic [QW-1:0] rm();
    if ($urandom_range(0, 7) == 0) return '0;
    return ($urandom_range(0, 1) != 0) ? QW'($urandom_range(1, 255)) : QW'($urandom_range(1, (1 << QW) - 1));
  endfunction

  always @(negedge clk) begin
    if (!rst) pv = 0;
    else begin
      if (o_valid) begin
        if (sb.size() == 0) begin
          ncmp++; nerr++;
          $display("FAIL spurious_valid: o_valid=1 with no vector outstanding");
        end else begin
          if (!pv) check("latency", 64'(cyc - int'(sb[0].acc)), 64'd5);
          check("result", {od, oc, ob, oa, osat, ozm}, {sb[0].outs, sb[0].sat, sb[0].zm});
          if (o_ready) void'(sb.pop_front());
        end
      end
      pv = o_valid;
    end
  end

  initial begin
    int hs, w;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ovalid", o_valid, 0);
    check("rst_outputs", {od, oc, ob, oa, osat, ozm}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_iready", i_ready, 1);
    send(153, 204, 0, 0, 5);
    send(128, 128, 128, 128, 20);
    send(512, 100, 50, 0, 200);
    send(77, 300, 9, 1000, 0);
    send(18'h3FFFF, 18'h3FFFF, 255, 256, 18'h3FFFF);
    wait_idle();
    // backpressure: hold o_ready low while a second vector waits upstream
    ready_force = 0;
    send(40, 80, 120, 160, 3);
    w = 0;
    while (!o_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("bp_reach_valid", o_valid, 1);
    qa = 256; qb = 1; qc = 2; qd = 3; mg = 9;
    i_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_ovalid_held", o_valid, 1);
      check("bp_iready_low", i_ready, 0);
    end
    ready_force = 1;
    hs = cyc + 1;
    send(256, 1, 2, 3, 9);
    check("bp_reaccept_edge", 64'(last_acc), 64'(hs + 1));
    wait_idle();
    // reset during the second multiply cycle abandons the vector
    send(1, 2, 3, 4, 100);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    sb.delete();
    check("midrst_ovalid", o_valid, 0);
    check("midrst_outputs", {od, oc, ob, oa, osat, ozm}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_iready", i_ready, 1);
    repeat (8) @(posedge clk);
    #1;
    send(256, 0, 0, 0, 7);
    wait_idle();
    check("post_rst_outA", oa, 7);
    rnd_bp = 1;
    repeat (60) send(rq(), rq(), rq(), rq(), rm());
    wait_idle();
    rnd_bp = 0;
    $display("== %0d vectors applied, %0d miscompares ==", napplied, nerr);
    $finish;
  end
endmodule
